// File: rtl/score_pkg.sv
// Shared types, item point values and winner codes for the score_keeper block.
package score_pkg;

    typedef enum logic [1:0] {
        SMALL_GOLD = 2'd0,
        BIG_GOLD   = 2'd1,
        DIAMOND    = 2'd2,
        ROCK       = 2'd3
    } item_kind_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        OVER = 2'd2
    } game_state_t;

    localparam logic [1:0] WIN_TIE   = 2'b00;
    localparam logic [1:0] WIN_LEFT  = 2'b01;
    localparam logic [1:0] WIN_RIGHT = 2'b10;

    localparam int unsigned SCORE_W = 14;
    localparam int unsigned SUM_W   = 17;
    localparam int unsigned BCD_W   = 16;

    function automatic logic [9:0] value_of(input item_kind_t kind);
        case (kind)
            SMALL_GOLD: value_of = 10'd50;
            BIG_GOLD:   value_of = 10'd250;
            DIAMOND:    value_of = 10'd600;
            default:    value_of = 10'd10;
        endcase
    endfunction

endpackage

// File: rtl/score_bin2bcd.sv
// Iterative double-dabble: one load cycle then 14 add-3/shift cycles; done pulses with the result.
module score_bin2bcd
    import score_pkg::*;
(
    input  logic               Clk,
    input  logic               reset,
    input  logic               start,
    input  logic [SCORE_W-1:0] bin,
    output logic               busy,
    output logic               done,
    output logic [BCD_W-1:0]   bcd
);

    logic [SCORE_W+BCD_W-1:0] work;
    logic [SCORE_W+BCD_W-1:0] adj;
    logic [3:0]               cnt;

    always_comb begin
        adj = work;
        for (int unsigned d = 0; d < 4; d++) begin
            if (adj[SCORE_W + 4*d +: 4] >= 4'd5)
                adj[SCORE_W + 4*d +: 4] = adj[SCORE_W + 4*d +: 4] + 4'd3;
        end
    end

    always_ff @(posedge Clk) begin
        if (reset) begin
            work <= '0;
            cnt  <= '0;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                work <= {{BCD_W{1'b0}}, bin};
                cnt  <= 4'(SCORE_W);
                busy <= 1'b1;
            end else if (busy) begin
                work <= {adj[SCORE_W+BCD_W-2:0], 1'b0};
                cnt  <= cnt - 4'd1;
                if (cnt == 4'd1) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

    assign bcd = work[SCORE_W+BCD_W-1:SCORE_W];

endmodule

// File: rtl/score_keeper.sv
// Two-player scoring from item catch levels plus round timer and winner.
// Define SCORE_BCD_EN to build the BCD score converters; otherwise BCD outputs are tied to 0.
module score_keeper
    import score_pkg::*;
#(
    parameter int unsigned N_ITEMS    = 8,
    parameter int unsigned TICK_DIV   = 50_000_000,
    parameter int unsigned ROUND_SECS = 60,
    parameter int unsigned SCORE_MAX  = 9999
)
(
    input  logic                 Clk,
    input  logic                 reset,
    input  logic                 is_new_game_start,
    input  logic [N_ITEMS-1:0]   destroyl,
    input  logic [N_ITEMS-1:0]   destroyr,
    input  logic [2*N_ITEMS-1:0] item_kind,
    output logic [SCORE_W-1:0]   score_l,
    output logic [SCORE_W-1:0]   score_r,
    output logic                 score_pulse_l,
    output logic                 score_pulse_r,
    output logic [6:0]           time_left,
    output logic                 game_over,
    output logic [1:0]           winner,
    output logic [BCD_W-1:0]     score_l_bcd,
    output logic [BCD_W-1:0]     score_r_bcd
);

    localparam int unsigned TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    game_state_t        state, state_n;
    logic [TICK_W-1:0]  tick_cnt;
    logic               tick_wrap;
    logic [N_ITEMS-1:0] prev_l, prev_r, rise_l, rise_r;
    logic [SUM_W-1:0]   sum_l, sum_r, cand_l, cand_r;
    logic [SCORE_W-1:0] score_l_d, score_r_d;
    logic               chg_l, chg_r;

    always_ff @(posedge Clk) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        if (is_new_game_start)                   state_n = PLAY;
        else if (state == PLAY && time_left == '0) state_n = OVER;
    end

    always_comb begin
        game_over = (state == OVER);
        winner    = WIN_TIE;
        if (state == OVER) begin
            if (score_l > score_r)      winner = WIN_LEFT;
            else if (score_r > score_l) winner = WIN_RIGHT;
        end
    end

    // An item held by both hooks belongs to the left player.
    assign rise_l = destroyl & ~prev_l;
    assign rise_r = destroyr & ~prev_r & ~destroyl;

    always_comb begin
        sum_l = '0;
        sum_r = '0;
        for (int unsigned i = 0; i < N_ITEMS; i++) begin
            if (rise_l[i]) sum_l = sum_l + SUM_W'(value_of(item_kind_t'(item_kind[2*i +: 2])));
            if (rise_r[i]) sum_r = sum_r + SUM_W'(value_of(item_kind_t'(item_kind[2*i +: 2])));
        end
        cand_l = SUM_W'(score_l) + sum_l;
        cand_r = SUM_W'(score_r) + sum_r;
        score_l_d = score_l;
        score_r_d = score_r;
        if (is_new_game_start) begin
            score_l_d = '0;
            score_r_d = '0;
        end else if (state == PLAY) begin
            score_l_d = (cand_l > SUM_W'(SCORE_MAX)) ? SCORE_W'(SCORE_MAX) : cand_l[SCORE_W-1:0];
            score_r_d = (cand_r > SUM_W'(SCORE_MAX)) ? SCORE_W'(SCORE_MAX) : cand_r[SCORE_W-1:0];
        end
    end

    assign chg_l = (score_l_d != score_l);
    assign chg_r = (score_r_d != score_r);

    always_ff @(posedge Clk) begin
        if (reset) begin
            score_l       <= '0;
            score_r       <= '0;
            score_pulse_l <= 1'b0;
            score_pulse_r <= 1'b0;
            prev_l        <= '0;
            prev_r        <= '0;
        end else begin
            score_l       <= score_l_d;
            score_r       <= score_r_d;
            score_pulse_l <= chg_l & ~is_new_game_start;
            score_pulse_r <= chg_r & ~is_new_game_start;
            prev_l        <= is_new_game_start ? '0 : destroyl;
            prev_r        <= is_new_game_start ? '0 : destroyr;
        end
    end

    assign tick_wrap = (tick_cnt == TICK_W'(TICK_DIV - 1));

    always_ff @(posedge Clk) begin
        if (reset || is_new_game_start) begin
            tick_cnt  <= '0;
            time_left <= 7'(ROUND_SECS);
        end else if (state == PLAY) begin
            if (tick_wrap) begin
                tick_cnt <= '0;
                if (time_left != '0) time_left <= time_left - 7'd1;
            end else begin
                tick_cnt <= tick_cnt + TICK_W'(1);
            end
        end
    end

`ifdef SCORE_BCD_EN
    logic               busy_l, busy_r, done_l, done_r;
    logic [BCD_W-1:0]   conv_l, conv_r;

    // Converters start on the pre-register score so the result lands 15 cycles after the pulse.
    score_bin2bcd u_bcd_l (
        .Clk   (Clk),
        .reset (reset),
        .start (chg_l),
        .bin   (score_l_d),
        .busy  (busy_l),
        .done  (done_l),
        .bcd   (conv_l)
    );

    score_bin2bcd u_bcd_r (
        .Clk   (Clk),
        .reset (reset),
        .start (chg_r),
        .bin   (score_r_d),
        .busy  (busy_r),
        .done  (done_r),
        .bcd   (conv_r)
    );

    always_ff @(posedge Clk) begin
        if (reset) begin
            score_l_bcd <= '0;
            score_r_bcd <= '0;
        end else begin
            if (done_l && !busy_l) score_l_bcd <= conv_l;
            if (done_r && !busy_r) score_r_bcd <= conv_r;
        end
    end
`else
    assign score_l_bcd = '0;
    assign score_r_bcd = '0;
`endif

endmodule

// File: tb/tb_score_keeper.sv
// Randomized and directed bench for score_keeper against a behavioural game model.
module tb_score_keeper;

    localparam int TD_L = 8;
    localparam int RS_L = 120;

    logic        Clk = 1'b0;
    logic        rst, start;
    logic [7:0]  dl, dr;
    logic [15:0] kind;

    logic [13:0] s_l, s_r, t_s_l, t_s_r;
    logic        p_l, p_r, t_p_l, t_p_r, go, t_go;
    logic [6:0]  tl, t_tl;
    logic [1:0]  win, t_win;
    logic [15:0] bcd_l, bcd_r, t_bcd_l, t_bcd_r;

    int checks = 0;
    int passes = 0;

    always #5 Clk = ~Clk;

    score_keeper #(.N_ITEMS(8), .TICK_DIV(TD_L), .ROUND_SECS(RS_L), .SCORE_MAX(9999)) dut (
        .Clk(Clk), .reset(rst), .is_new_game_start(start), .destroyl(dl), .destroyr(dr),
        .item_kind(kind), .score_l(s_l), .score_r(s_r), .score_pulse_l(p_l), .score_pulse_r(p_r),
        .time_left(tl), .game_over(go), .winner(win), .score_l_bcd(bcd_l), .score_r_bcd(bcd_r)
    );

    score_keeper #(.N_ITEMS(8), .TICK_DIV(4), .ROUND_SECS(3), .SCORE_MAX(9999)) dut_t (
        .Clk(Clk), .reset(rst), .is_new_game_start(start), .destroyl(dl), .destroyr(dr),
        .item_kind(kind), .score_l(t_s_l), .score_r(t_s_r), .score_pulse_l(t_p_l), .score_pulse_r(t_p_r),
        .time_left(t_tl), .game_over(t_go), .winner(t_win), .score_l_bcd(t_bcd_l), .score_r_bcd(t_bcd_r)
    );

    // Game model for the long-round instance: phase 0 idle, 1 playing, 2 finished.
    int         vals [4] = '{50, 250, 600, 10};
    int         m_sl, m_sr, m_tl, m_tick, m_phase, m_win;
    bit         m_pl, m_pr;
    logic [7:0] m_prev_l, m_prev_r;

    always @(posedge Clk) begin
        int gl, gr, nl, nr;
        if (rst) begin
            m_sl = 0; m_sr = 0; m_pl = 0; m_pr = 0; m_phase = 0;
            m_tl = RS_L; m_tick = 0; m_prev_l = '0; m_prev_r = '0;
        end else if (start) begin
            m_sl = 0; m_sr = 0; m_pl = 0; m_pr = 0; m_phase = 1;
            m_tl = RS_L; m_tick = 0; m_prev_l = '0; m_prev_r = '0;
        end else begin
            gl = 0; gr = 0;
            for (int i = 0; i < 8; i++) begin
                if (dl[i] && !m_prev_l[i]) gl += vals[kind[2*i +: 2]];
                if (dr[i] && !m_prev_r[i] && !dl[i]) gr += vals[kind[2*i +: 2]];
            end
            m_pl = 0; m_pr = 0;
            if (m_phase == 1) begin
                nl = (m_sl + gl > 9999) ? 9999 : m_sl + gl;
                nr = (m_sr + gr > 9999) ? 9999 : m_sr + gr;
                m_pl = (nl != m_sl); m_pr = (nr != m_sr);
                m_sl = nl; m_sr = nr;
                if (m_tl == 0) m_phase = 2;
                else begin
                    m_tick++;
                    if (m_tick == TD_L) begin m_tick = 0; m_tl--; end
                end
            end
            m_prev_l = dl; m_prev_r = dr;
        end
        m_win = (m_phase != 2) ? 0 : (m_sl > m_sr) ? 1 : (m_sr > m_sl) ? 2 : 0;
    end

    function automatic logic [15:0] to_bcd(input int v);
        to_bcd = {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1; start = 0; dl = '0; dr = '0; kind = 16'h00D2;
        repeat (2) step();
        rst = 0;
        checks++; if (s_l !== 14'd0) $display("FAIL reset_score_l got %0d want 0", s_l); else passes++;
        checks++; if (s_r !== 14'd0) $display("FAIL reset_score_r got %0d want 0", s_r); else passes++;
        checks++; if ({p_l, p_r} !== 2'b00) $display("FAIL reset_pulses got %b want 00", {p_l, p_r}); else passes++;
        checks++; if (tl !== 7'd120) $display("FAIL reset_time_left got %0d want 120", tl); else passes++;
        checks++; if (t_tl !== 7'd3) $display("FAIL reset_time_left_t got %0d want 3", t_tl); else passes++;
        checks++; if ({go, win} !== 3'b000) $display("FAIL reset_over_winner got %b want 000", {go, win}); else passes++;
        checks++; if ({bcd_l, bcd_r} !== 32'h0) $display("FAIL reset_bcd got %h want 0", {bcd_l, bcd_r}); else passes++;
        dl = 8'b100;
        step();
        dl = '0;
        checks++; if (s_l !== 14'd0 || p_l !== 1'b0) $display("FAIL idle_no_award got %0d/%b want 0/0", s_l, p_l); else passes++;
        step();
    endtask

    task automatic test_hold();
        int npulse = 0;
        start = 1; step(); start = 0;
        checks++; if (tl !== 7'd120) $display("FAIL start_time_left got %0d want 120", tl); else passes++;
        dl = 8'b100;
        for (int c = 0; c < 10; c++) begin
            step();
            if (p_l) npulse++;
            if (c == 0) begin
                checks++; if (s_l !== 14'd250 || p_l !== 1'b1) $display("FAIL hold_first got %0d/%b want 250/1", s_l, p_l); else passes++;
            end
        end
        dl = '0;
        step();
        checks++; if (s_l !== 14'd250) $display("FAIL hold_score_l got %0d want 250", s_l); else passes++;
        checks++; if (npulse != 1) $display("FAIL hold_pulse_count got %0d want 1", npulse); else passes++;
        checks++; if (s_r !== 14'd0) $display("FAIL hold_score_r got %0d want 0", s_r); else passes++;
    endtask

    task automatic test_same_cycle();
        start = 1; step(); start = 0;
        dl = 8'b0000_0011; dr = 8'b0000_1000;
        step();
        dl = '0; dr = '0;
        checks++; if (s_l !== 14'd650) $display("FAIL multi_score_l got %0d want 650", s_l); else passes++;
        checks++; if (s_r !== 14'd10) $display("FAIL multi_score_r got %0d want 10", s_r); else passes++;
        checks++; if ({p_l, p_r} !== 2'b11) $display("FAIL multi_pulses got %b want 11", {p_l, p_r}); else passes++;
        step();
        checks++; if ({p_l, p_r} !== 2'b00) $display("FAIL multi_pulse_width got %b want 00", {p_l, p_r}); else passes++;
    endtask

    task automatic test_saturation();
        logic [15:0] exp_old, exp_new;
`ifdef SCORE_BCD_EN
        exp_old = 16'h9900; exp_new = 16'h9999;
`else
        exp_old = 16'h0; exp_new = 16'h0;
`endif
        start = 1; step(); start = 0;
        for (int k = 0; k < 16; k++) begin
            dl = 8'b1; step(); dl = '0; step();
        end
        dl = 8'b100; step(); dl = '0; step();
        dl = 8'b010; step(); dl = '0; step();
        checks++; if (s_l !== 14'd9900) $display("FAIL preload got %0d want 9900", s_l); else passes++;
        repeat (16) step();
        checks++; if (bcd_l !== exp_old) $display("FAIL bcd_settled got %h want %h", bcd_l, exp_old); else passes++;
        dl = 8'b1; step(); dl = '0;
        checks++; if (s_l !== 14'd9999 || p_l !== 1'b1) $display("FAIL sat_hit got %0d/%b want 9999/1", s_l, p_l); else passes++;
        repeat (14) step();
        checks++; if (bcd_l !== exp_old) $display("FAIL bcd_early got %h want %h", bcd_l, exp_old); else passes++;
        step();
        checks++; if (bcd_l !== exp_new) $display("FAIL bcd_latency got %h want %h", bcd_l, exp_new); else passes++;
        dl = 8'b1; step(); dl = '0;
        checks++; if (s_l !== 14'd9999 || p_l !== 1'b0) $display("FAIL sat_hold got %0d/%b want 9999/0", s_l, p_l); else passes++;
        step();
    endtask

    task automatic test_timer();
        start = 1; step(); start = 0;
        dl = 8'b10; dr = 8'b01;
        step();
        dl = '0; dr = '0;
        checks++; if (t_s_l !== 14'd50 || t_s_r !== 14'd600) $display("FAIL timer_scores got %0d/%0d want 50/600", t_s_l, t_s_r); else passes++;
        repeat (2) step();
        checks++; if (t_tl !== 7'd3) $display("FAIL timer_before_wrap got %0d want 3", t_tl); else passes++;
        step();
        checks++; if (t_tl !== 7'd2) $display("FAIL timer_first_wrap got %0d want 2", t_tl); else passes++;
        repeat (8) step();
        checks++; if (t_tl !== 7'd0 || t_go !== 1'b0) $display("FAIL timer_zero got %0d/%b want 0/0", t_tl, t_go); else passes++;
        step();
        checks++; if (t_go !== 1'b1) $display("FAIL game_over got %b want 1", t_go); else passes++;
        checks++; if (t_win !== 2'b10) $display("FAIL winner got %b want 10", t_win); else passes++;
        dl = 8'b100; step(); dl = '0;
        checks++; if (t_s_l !== 14'd50 || t_p_l !== 1'b0) $display("FAIL over_no_award got %0d/%b want 50/0", t_s_l, t_p_l); else passes++;
        checks++; if (t_tl !== 7'd0 || t_go !== 1'b1) $display("FAIL over_hold got %0d/%b want 0/1", t_tl, t_go); else passes++;
    endtask

    task automatic test_reset_mid();
        start = 1; step(); start = 0;
        dl = 8'b100; step(); dl = '0;
        checks++; if (t_s_l !== 14'd250) $display("FAIL mid_score got %0d want 250", t_s_l); else passes++;
        step();
        rst = 1; start = 1; step(); rst = 0; start = 0;
        checks++; if (t_s_l !== 14'd0 || t_tl !== 7'd3 || t_go !== 1'b0) $display("FAIL mid_reset got %0d/%0d/%b want 0/3/0", t_s_l, t_tl, t_go); else passes++;
        dl = 8'b100; step(); dl = '0;
        checks++; if (t_s_l !== 14'd0) $display("FAIL reset_wins_start got %0d want 0", t_s_l); else passes++;
        start = 1; dr = 8'b1000; step(); start = 0; dr = '0;
        step();
        checks++; if (t_s_r !== 14'd0 || s_r !== 14'd0) $display("FAIL start_clears_edge got %0d/%0d want 0/0", t_s_r, s_r); else passes++;
    endtask

    task automatic test_random();
        int b;
        kind = 16'($urandom);
        dl = '0; dr = '0;
        start = 1; step(); start = 0;
        for (int c = 0; c < 1400; c++) begin
            if ($urandom_range(9) == 0) begin b = $urandom_range(7); dl[b] = ~dl[b]; end
            if ($urandom_range(9) == 0) begin b = $urandom_range(7); dr[b] = ~dr[b]; end
            start = (c < 300 && $urandom_range(127) == 0);
            step();
            checks++; if (s_l !== 14'(m_sl)) $display("FAIL rnd_score_l c=%0d got %0d want %0d", c, s_l, m_sl); else passes++;
            checks++; if (s_r !== 14'(m_sr)) $display("FAIL rnd_score_r c=%0d got %0d want %0d", c, s_r, m_sr); else passes++;
            checks++; if ({p_l, p_r} !== {m_pl, m_pr}) $display("FAIL rnd_pulses c=%0d got %b want %b", c, {p_l, p_r}, {m_pl, m_pr}); else passes++;
            checks++; if (tl !== 7'(m_tl)) $display("FAIL rnd_time_left c=%0d got %0d want %0d", c, tl, m_tl); else passes++;
            checks++; if (go !== (m_phase == 2)) $display("FAIL rnd_game_over c=%0d got %b want %0d", c, go, m_phase == 2); else passes++;
            checks++; if (win !== 2'(m_win)) $display("FAIL rnd_winner c=%0d got %b want %0d", c, win, m_win); else passes++;
        end
        start = 0; dl = '0; dr = '0;
        repeat (20) step();
`ifdef SCORE_BCD_EN
        checks++; if ({bcd_l, bcd_r} !== {to_bcd(m_sl), to_bcd(m_sr)}) $display("FAIL rnd_bcd got %h want %h", {bcd_l, bcd_r}, {to_bcd(m_sl), to_bcd(m_sr)}); else passes++;
`else
        checks++; if ({bcd_l, bcd_r} !== 32'h0) $display("FAIL rnd_bcd got %h want 0", {bcd_l, bcd_r}); else passes++;
`endif
    endtask

    initial begin
        test_reset();
        test_hold();
        test_same_cycle();
        test_saturation();
        test_timer();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
